// File: rtl/shift_left_pipe_if.sv
// Handshake and data bundle for the pipelined left shift / rotate unit.
// master = operand producer and result consumer; slave = the shift unit.
// The carry signal exists only when SHL_CARRY_EN is defined.
interface shift_left_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               shift_rot;
  logic [SHAMT_W-1:0] r;
  logic [WIDTH-1:0]   x;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               zero;
`ifdef SHL_CARRY_EN
  logic               carry;

  modport master (
    output in_valid, shift_rot, r, x, out_ready,
    input  in_ready, out_valid, y, zero, carry
  );

  modport slave (
    input  in_valid, shift_rot, r, x, out_ready,
    output in_ready, out_valid, y, zero, carry
  );
`else
  modport master (
    output in_valid, shift_rot, r, x, out_ready,
    input  in_ready, out_valid, y, zero
  );

  modport slave (
    input  in_valid, shift_rot, r, x, out_ready,
    output in_ready, out_valid, y, zero
  );
`endif
endinterface

// File: rtl/shift_left_pipe.sv
// Pipelined logical shift left / rotate left, one registered stage per amount bit (MSB first).
// Latency: SHAMT_W cycles from accepted operand to out_valid, plus one per stall cycle; 1 result/cycle.
// Backpressure: whole pipe holds while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
// Optional macro SHL_CARRY_EN adds a registered carry output (last bit shifted out / wrapped in).
module shift_left_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  shift_left_pipe_if.slave bus
);

  // Stage decomposition only covers every amount when WIDTH is exactly 2^SHAMT_W.
  if ((1 << SHAMT_W) != WIDTH) begin : g_param_check
    $error("shift_left_pipe: WIDTH must equal 2**SHAMT_W");
  end

  // Stage registers. Stage k decides on amount bit SHAMT_W-1-k. The amount is
  // kept left-aligned (shifted up by one per stage) so every stage looks at the
  // MSB of what it receives; the last stage needs neither amount nor mode.
  logic [SHAMT_W-1:0] vld;
  logic [WIDTH-1:0]   dat [SHAMT_W];
  logic [SHAMT_W-1:0] amt [SHAMT_W-1];
  logic [SHAMT_W-2:0] rot;
  logic               zero_q;

  logic [SHAMT_W-1:0] nxt_vld;
  logic [WIDTH-1:0]   nxt_dat [SHAMT_W];
  logic [SHAMT_W-1:0] nxt_amt [SHAMT_W-1];
  logic [SHAMT_W-2:0] nxt_rot;

`ifdef SHL_CARRY_EN
  logic [SHAMT_W-1:0] cy;
  logic [SHAMT_W-1:0] nxt_cy;
`endif

  logic adv;

  // All stages move together; a held result freezes the entire pipe.
  assign adv           = ~vld[SHAMT_W-1] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[SHAMT_W-1];
  assign bus.y         = dat[SHAMT_W-1];
  assign bus.zero      = zero_q;
`ifdef SHL_CARRY_EN
  assign bus.carry     = cy[SHAMT_W-1];
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << (SHAMT_W - 1 - k);

    logic             act;
    logic             rot_in;
    logic [WIDTH-1:0] d_in;
    logic [S-1:0]     wrap;

    // Stage 0 reads the operand port, later stages read the previous register.
    if (k == 0) begin : g_src
      assign act        = bus.r[SHAMT_W-1];
      assign rot_in     = bus.shift_rot;
      assign d_in       = bus.x;
      assign nxt_vld[0] = bus.in_valid;
    end else begin : g_src
      assign act        = amt[k-1][SHAMT_W-1];
      assign rot_in     = rot[k-1];
      assign d_in       = dat[k-1];
      assign nxt_vld[k] = vld[k-1];
    end

    // Remaining amount bits and mode ride along with the data.
    if (k < SHAMT_W - 1) begin : g_fwd
      if (k == 0) begin : g_amt
        assign nxt_amt[k] = bus.r << 1;
      end else begin : g_amt
        assign nxt_amt[k] = amt[k-1] << 1;
      end
      assign nxt_rot[k] = rot_in;
    end

    // Vacated LSBs: zero fill for shift, the top S bits for rotate.
    assign wrap       = rot_in ? d_in[WIDTH-1 -: S] : '0;
    assign nxt_dat[k] = act ? {d_in[WIDTH-S-1:0], wrap} : d_in;

`ifdef SHL_CARRY_EN
    // An active stage's carry is bit WIDTH-S of its input: the last bit pushed
    // out on a shift, and the bit that lands in the LSB on a rotate.
    logic cy_in;
    if (k == 0) begin : g_cy
      assign cy_in = 1'b0;
    end else begin : g_cy
      assign cy_in = cy[k-1];
    end
    assign nxt_cy[k] = act ? d_in[WIDTH-S] : cy_in;
`endif
  end

  // Pipeline registers: cleared on reset, loaded together whenever the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      rot    <= '0;
      zero_q <= 1'b0;
      for (int i = 0; i < SHAMT_W; i++) begin
        dat[i] <= '0;
      end
      for (int i = 0; i < SHAMT_W - 1; i++) begin
        amt[i] <= '0;
      end
    end else if (adv) begin
      vld    <= nxt_vld;
      rot    <= nxt_rot;
      zero_q <= (nxt_dat[SHAMT_W-1] == '0);
      dat    <= nxt_dat;
      amt    <= nxt_amt;
    end
  end

`ifdef SHL_CARRY_EN
  // Carry tracking registers, advancing in lockstep with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy <= '0;
    end else if (adv) begin
      cy <= nxt_cy;
    end
  end
`endif

endmodule

// File: tb/tb_shift_left_pipe.sv
// Bench for shift_left_pipe: directed vector table, back-to-back sweep,
// random backpressure, and reset with operands in flight; scoreboard-checked.
module tb_shift_left_pipe;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef struct {
    logic [31:0] x;
    logic [4:0]  r;
    logic        rot;
    logic [31:0] y;
    logic        zero;
    logic        carry;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        carry;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_left_pipe_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus();

  shift_left_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          rand_rdy = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_y;
  logic        held_z;
  vec_t        tbl[13];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end

  function automatic vec_t mk(input logic [31:0] x, input logic [4:0] r, input logic rot,
                              input logic [31:0] y, input logic z, input logic c);
    vec_t v;
    v.x = x; v.r = r; v.rot = rot; v.y = y; v.zero = z; v.carry = c;
    return v;
  endfunction

  // Reference: move each operand bit to its destination position.
  function automatic vec_t model(input logic [31:0] x, input logic [4:0] r, input logic rot);
    vec_t v;
    v.x = x; v.r = r; v.rot = rot; v.y = '0;
    for (int i = 0; i < 32; i++) begin
      int j;
      j = i + int'(r);
      if (j < 32) v.y[j] = x[i];
      else if (rot) v.y[j-32] = x[i];
    end
    v.zero = (v.y == 32'h0);
    if (r == 5'd0) v.carry = 1'b0;
    else if (rot) v.carry = v.y[0];
    else v.carry = x[32 - int'(r)];
    return v;
  endfunction

  // Present one operand starting at posedge+1; push its expectation when accepted.
  task automatic send(input vec_t v, input bit lchk);
    exp_t e;
    bit   ok;
    bus.x = v.x; bus.r = v.r; bus.shift_rot = v.rot; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    e.y = v.y; e.zero = v.zero; e.carry = v.carry; e.cyc = cyc; e.lat = lchk;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  // Output monitor: scoreboard pops, latency, and hold-while-stalled checks.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.y !== held_y || bus.zero !== held_z) begin
          n_err++;
          $display("FAIL stall_hold: got vld=%b y=%h z=%b, required vld=1 y=%h z=%b",
                   bus.out_valid, bus.y, bus.zero, held_y, held_z);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got y=%h, required no output", bus.y);
        end else begin
          exp_t e;
          bit   ok;
          logic got_c;
          e = sb.pop_front();
          ok = (bus.y === e.y) && (bus.zero === e.zero);
`ifdef SHL_CARRY_EN
          got_c = bus.carry;
          ok = ok && (got_c === e.carry);
`else
          got_c = 1'bx;
`endif
          n_vec++;
          if (!ok) begin
            n_err++;
            $display("FAIL result: got y=%h z=%b c=%b, required y=%h z=%b c=%b",
                     bus.y, bus.zero, got_c, e.y, e.zero, e.carry);
          end
          if (e.lat) begin
            n_vec++;
            if (cyc - e.cyc != SHAMT_W) begin
              n_err++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.cyc, SHAMT_W);
            end
          end
        end
      end
      stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      held_y = bus.y;
      held_z = bus.zero;
    end
  end

  initial begin
    int seen;
    tbl[0]  = mk(32'h0000_00FF, 5'd8,  1'b0, 32'h0000_FF00, 1'b0, 1'b0);
    tbl[1]  = mk(32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003, 1'b0, 1'b1);
    tbl[2]  = mk(32'h8000_0000, 5'd1,  1'b0, 32'h0000_0000, 1'b1, 1'b1);
    tbl[3]  = mk(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b0, 1'b0);
    tbl[4]  = mk(32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tbl[5]  = mk(32'h1234_5678, 5'd4,  1'b1, 32'h2345_6781, 1'b0, 1'b1);
    tbl[6]  = mk(32'h1234_5678, 5'd4,  1'b0, 32'h2345_6780, 1'b0, 1'b1);
    tbl[7]  = mk(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    tbl[8]  = mk(32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    tbl[9]  = mk(32'h0000_0003, 5'd31, 1'b1, 32'h8000_0001, 1'b0, 1'b1);
    tbl[10] = mk(32'h0000_FFFF, 5'd16, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0);
    tbl[11] = mk(32'h0000_0000, 5'd7,  1'b1, 32'h0000_0000, 1'b1, 1'b0);
    tbl[12] = mk(32'hA5A5_A5A5, 5'd1,  1'b0, 32'h4B4B_4B4A, 1'b0, 1'b1);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.shift_rot = 1'b0; bus.r = '0; bus.x = '0;
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'h0 || bus.zero !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got vld=%b y=%h z=%b rdy=%b, required vld=0 y=0 z=0 rdy=1",
               bus.out_valid, bus.y, bus.zero, bus.in_ready);
    end
`ifdef SHL_CARRY_EN
    n_vec++;
    if (bus.carry !== 1'b0) begin
      n_err++;
      $display("FAIL reset_carry: got %b, required 0", bus.carry);
    end
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, issued back to back.
    foreach (tbl[i]) send(tbl[i], 1'b1);
    drain();

    // Full amount sweep in both modes, one operand per cycle.
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 32; a++)
        send(model(32'hDEAD_BEEF, 5'(a), 1'(m)), 1'b1);
    drain();

    // Random operands, random gaps, random downstream readiness.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #0;
      send(model($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))), 1'b0);
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset with three operands in flight and the head result stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tbl[5 + i], 1'b0);
    for (int t = 0; t < 20 && bus.out_valid !== 1'b1; t++) @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL prefill: got out_valid=%b, required 1", bus.out_valid);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'h0 || bus.zero !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got vld=%b y=%h z=%b, required vld=0 y=0 z=0",
               bus.out_valid, bus.y, bus.zero);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL stale_after_reset: got %0d valid cycles, required 0", seen);
    end

    // Recovery after reset.
    @(posedge clk); #1;
    send(tbl[0], 1'b1);
    send(tbl[2], 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
